lvds_rx_word_align: RTL and testbench
=====================================

// Module: lvds_rx_word_align
// PURPOSE
//  Receive-side counterpart of the DAC LVDS transmit path (1 Gbps line rate, 8:1 SERDES).
//  Takes 8-bit words from an ISERDESE3 running on the f500m_clk/f125m_clk pair and finds
//  the word boundary against a known training pattern, using a fabric bit-window shifter.
//  After lock it outputs aligned words. Used for loopback/link bring-up of the SERDES lanes.
// PARAMETERS
//  TRAIN_PATTERN  8'h1E  training word; all 8 rotations are distinct
//  MATCH_CNT      16     consecutive matches required to declare lock (2..255)
//  SETTLE         3      wait cycles after slip_pos change before comparing (>=2)
//  MAX_SWEEPS     4      full 8-offset sweeps without lock before align_fail
//  ERR_LIMIT      4      consecutive mismatches in LOCKED (train_active=1) that force relock
// PORTS
//  f125m_clk     in   1  parallel word clock (only clock of the block)
//  rst_n         in   1  synchronous, active-low reset
//  align_start   in   1  1-cycle pulse: restart the alignment from offset 0
//  train_active  in   1  peer is currently sending TRAIN_PATTERN (enables LOCKED monitoring)
//  din           in   8  ISERDESE3 Q word; din[0] = earliest received bit
//  dout          out  8  aligned word; dout[0] = earliest bit
//  dout_valid    out  1  1 while LOCKED
//  locked        out  1  word boundary found
//  align_fail    out  1  sticky until align_start/reset: no lock after MAX_SWEEPS sweeps
//  slip_pos      out  3  current bit offset 0..7
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge): dout=0, dout_valid=0, locked=0, align_fail=0, slip_pos=0, state=IDLE.
//  - Datapath: din_d <= din; win = {din, din_d}; dout <= win[slip_pos +: 8]. Latency din->dout = 2 cycles.
//  - FSM states: IDLE, SETTLE, SEARCH, CHECK, LOCKED, FAIL.
//    IDLE: wait for align_start -> SETTLE (slip_pos=0, sweep=0).
//    SETTLE: count SETTLE cycles -> SEARCH.
//    SEARCH: if dout==TRAIN_PATTERN -> CHECK (match_cnt=1); else slip.
//    CHECK: match -> match_cnt++; if it reaches MATCH_CNT -> LOCKED. Mismatch -> slip.
//    slip: slip_pos++; on wrap 7->0, sweep++; if sweep reaches MAX_SWEEPS -> FAIL, else -> SETTLE.
//    LOCKED: locked=1, dout_valid=1. If train_active=1, count consecutive mismatches;
//      when the count reaches ERR_LIMIT -> drop locked/dout_valid the next cycle, slip, go to SETTLE (sweep=0).
//      A match, or train_active=0, clears the mismatch count. Payload passes through untouched.
//    FAIL: align_fail=1, locked=0; hold slip_pos; leave only on align_start.
//  - align_start in any state (including mid-CHECK or LOCKED): slip_pos=0, counters cleared,
//    align_fail=0, locked=0 -> SETTLE. align_start takes priority over a lock or a fail in the same cycle.
//  - locked and dout_valid are always equal. Counters saturate; they never wrap.
// CONFIGURATION
//  `RX_ALIGN_ERR_CNT_EN defined: adds output err_cnt[15:0]. It counts mismatched words while
//    LOCKED and train_active=1, saturates at 16'hFFFF, and is cleared by reset or align_start.
//  Not defined: no err_cnt port and no counter logic. All other behaviour is identical.
// STRUCTURE
//  rx_align_pkg: state enum (IDLE..FAIL), default TRAIN_PATTERN constant, width localparams.
//  Sub-module rx_bit_window: din_d register plus the 16->8 shifter selected by slip_pos
//    (registered output). The FSM and counters stay in lvds_rx_word_align.
// TESTING
//  1 Serial 8'h1E stream rotated by 3 bits, pulse align_start -> locked=1 with slip_pos=3,
//    within 4 offsets*(SETTLE+1) + MATCH_CNT + 2 cycles; dout==8'h1E thereafter.
//  2 Each offset 0..7 -> locks at that slip_pos; offset 7 checks wrap-free lock at the highest offset.
//  3 din fixed at 8'h00 -> align_fail=1 after 4 sweeps (32 slips); locked stays 0; align_start clears align_fail.
//  4 Locked at offset 5, inject 3 bad words -> stays locked; inject 4 bad words -> locked=0 one cycle later, relocks at 5.
//  5 Locked, train_active=0, send payload 8'hC3.. -> no relock; dout equals the payload aligned at offset 5, 2-cycle latency.
//  6 rst_n=0 mid-CHECK -> all outputs 0 next edge; with RX_ALIGN_ERR_CNT_EN, 10 bad words in LOCKED -> err_cnt=10.

Source files
------------

// File: rtl/rx_align_pkg.sv
// Shared types and constants for the LVDS receive word aligner.
// The optional error counter is enabled with `RX_ALIGN_ERR_CNT_EN.
package rx_align_pkg;

  localparam int WORD_W    = 8;
  localparam int POS_W     = 3;
  localparam int CNT_W     = 8;
  localparam int ERR_CNT_W = 16;

  localparam logic [WORD_W-1:0] DEF_TRAIN_PATTERN = 8'h1E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEARCH,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_bit_window.sv
// Fabric bit-window shifter: holds the previous word and selects an 8-bit
// slice of {current, previous} at the requested bit offset (registered).
module rx_bit_window
  import rx_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] din,
  input  logic [POS_W-1:0]  slip_pos,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0]   din_q;
  logic [WORD_W-1:0]   dout_q;
  logic [WORD_W-1:0]   dout_d;
  logic [2*WORD_W-1:0] win;
  logic [WORD_W-1:0]   taps [WORD_W];

  // Lower half is the older word, so bit 0 of the window is the earliest bit.
  assign win = {din, din_q};

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_tap
      assign taps[gi] = win[gi +: WORD_W];
    end
  endgenerate

  assign dout_d = taps[slip_pos];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q  <= '0;
      dout_q <= '0;
    end else begin
      din_q  <= din;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/lvds_rx_word_align.sv
// Word-boundary aligner for an 8:1 SERDES lane: sweeps bit offsets against a
// training word, locks, and monitors lock. `RX_ALIGN_ERR_CNT_EN adds err_cnt.
module lvds_rx_word_align
  import rx_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int                MATCH_CNT     = 16,
  parameter int                SETTLE        = 3,
  parameter int                MAX_SWEEPS    = 4,
  parameter int                ERR_LIMIT     = 4
)(
  input  logic                 f125m_clk,
  input  logic                 rst_n,
  input  logic                 align_start,
  input  logic                 train_active,
  input  logic [WORD_W-1:0]    din,
  output logic [WORD_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic                 align_fail,
  output logic [POS_W-1:0]     slip_pos
`ifdef RX_ALIGN_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  slip_q, slip_d;
  logic [CNT_W-1:0]  sweep_q, sweep_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  errrun_q, errrun_d;
  logic [WORD_W-1:0] word;
  logic              word_match;
  logic              do_slip;

  rx_bit_window u_window (
    .clk      (f125m_clk),
    .rst_n    (rst_n),
    .din      (din),
    .slip_pos (slip_q),
    .dout     (word)
  );

  assign word_match = (word == TRAIN_PATTERN);

  always_ff @(posedge f125m_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      slip_q   <= '0;
      sweep_q  <= '0;
      settle_q <= '0;
      match_q  <= '0;
      errrun_q <= '0;
    end else begin
      state_q  <= state_d;
      slip_q   <= slip_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      errrun_q <= errrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    sweep_d  = sweep_q;
    settle_d = settle_q;
    match_d  = match_q;
    errrun_d = errrun_q;
    do_slip  = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q >= CNT_W'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = ST_SEARCH;
        end else begin
          settle_d = sat_inc(settle_q);
        end
      end
      ST_SEARCH: begin
        if (word_match) begin
          match_d = CNT_W'(1);
          state_d = ST_CHECK;
        end else begin
          do_slip = 1'b1;
        end
      end
      ST_CHECK: begin
        if (word_match) begin
          match_d = sat_inc(match_q);
          if (sat_inc(match_q) >= CNT_W'(MATCH_CNT)) begin
            errrun_d = '0;
            state_d  = ST_LOCKED;
          end
        end else begin
          do_slip = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (train_active && !word_match) begin
          errrun_d = sat_inc(errrun_q);
          // Relock starts a fresh sweep budget from the next offset.
          if (sat_inc(errrun_q) >= CNT_W'(ERR_LIMIT)) begin
            slip_d   = slip_q + 1'b1;
            sweep_d  = '0;
            settle_d = '0;
            match_d  = '0;
            errrun_d = '0;
            state_d  = ST_SETTLE;
          end
        end else begin
          errrun_d = '0;
        end
      end
      default: ;
    endcase

    if (do_slip) begin
      slip_d   = slip_q + 1'b1;
      settle_d = '0;
      match_d  = '0;
      state_d  = ST_SETTLE;
      if (slip_q == '1) begin
        sweep_d = sat_inc(sweep_q);
        if (sat_inc(sweep_q) >= CNT_W'(MAX_SWEEPS)) begin
          state_d = ST_FAIL;
        end
      end
    end

    if (align_start) begin
      state_d  = ST_SETTLE;
      slip_d   = '0;
      sweep_d  = '0;
      settle_d = '0;
      match_d  = '0;
      errrun_d = '0;
    end
  end

`ifdef RX_ALIGN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (align_start) begin
      err_cnt_d = '0;
    end else if (state_q == ST_LOCKED && train_active && !word_match && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge f125m_clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign dout       = word;
  assign locked     = (state_q == ST_LOCKED);
  assign dout_valid = (state_q == ST_LOCKED);
  assign align_fail = (state_q == ST_FAIL);
  assign slip_pos   = slip_q;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Self-checking bench for lvds_rx_word_align: a serial bit-stream model
// generates words and predicts the aligned output at the expected offset.
module tb_lvds_rx_word_align;

  localparam logic [7:0] PAT        = 8'h1E;
  localparam int         MATCH_CNT  = 16;
  localparam int         SETTLE     = 3;
  localparam int         MAX_SWEEPS = 4;
  localparam int         ERR_LIMIT  = 4;

  typedef enum {M_TRAIN, M_ZERO, M_PAY} mode_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       align_start = 1'b0;
  logic       train_active = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       align_fail;
  logic [2:0] slip_pos;
`ifdef RX_ALIGN_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  lvds_rx_word_align dut (
    .f125m_clk    (clk),
    .rst_n        (rst_n),
    .align_start  (align_start),
    .train_active (train_active),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .locked       (locked),
    .align_fail   (align_fail),
    .slip_pos     (slip_pos)
`ifdef RX_ALIGN_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #4 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  mode_e      mode = M_TRAIN;
  int         phase = 0;
  bit         bits_q[$];
  bit         flip_frame[int];
  logic [7:0] pay[int];
  int         c3_frame = -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial stream: frame f at the current phase occupies bits 8f+phase .. 8f+phase+7.
  task automatic push_word();
    logic [7:0] w;
    logic [7:0] pat;
    int i, idx, r, f;
    bit b;
    pat = PAT;
    for (int j = 0; j < 8; j++) begin
      i   = bits_q.size();
      idx = i + 8 - phase;
      r   = idx % 8;
      f   = idx / 8 - 1;
      b   = 1'b0;
      case (mode)
        M_TRAIN: b = pat[r] ^ (r == 0 && flip_frame.exists(f));
        M_PAY: begin
          if (!pay.exists(f)) pay[f] = (f == c3_frame) ? 8'hC3 : 8'($urandom);
          b = pay[f][r];
        end
        default: b = 1'b0;
      endcase
      w[j] = b;
      bits_q.push_back(b);
    end
    din = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    push_word();
  endtask

  // Output after an edge covers the stream two words back, starting at bit offset s.
  function automatic logic [7:0] exp_dout(input int s);
    logic [7:0] r;
    int base;
    base = 8 * (bits_q.size() / 8 - 3) + s;
    for (int j = 0; j < 8; j++) r[j] = (base + j >= 0) ? bits_q[base + j] : 1'b0;
    return r;
  endfunction

  function automatic int next_frame();
    return (bits_q.size() + 8 - phase) / 8;
  endfunction

  task automatic pulse_start();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
  endtask

  task automatic wait_lock(input int bound, output int n);
    n = 0;
    while (locked !== 1'b1 && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, bad, drops, vbad, run, reached, early;
    int ofs[8];
    int f0;

    // Reset state
    for (int k = 0; k < 3; k++) step();
    chk("rst_dout", {8'h00, dout}, 16'h0);
    chk("rst_valid", {15'h0, dout_valid}, 16'h0);
    chk("rst_locked", {15'h0, locked}, 16'h0);
    chk("rst_fail", {15'h0, align_fail}, 16'h0);
    chk("rst_slip", {13'h0, slip_pos}, 16'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("idle_locked", {15'h0, locked}, 16'h0);

    // Test 1: offset 3 within the stated lock time
    phase = 3;
    for (int k = 0; k < 3; k++) step();
    pulse_start();
    wait_lock(4 * (SETTLE + 1) + MATCH_CNT + 2, n);
    chk("t1_locked", {15'h0, locked}, 16'h1);
    chk("t1_slip", {13'h0, slip_pos}, 16'd3);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (dout !== PAT) bad++;
    end
    chk("t1_dout_bad", 16'(bad), 16'h0);

    // Test 2: every offset, random order
    for (int k = 0; k < 8; k++) ofs[k] = k;
    for (int k = 7; k > 0; k--) begin
      int j, t;
      j = int'($urandom_range(k, 0));
      t = ofs[k]; ofs[k] = ofs[j]; ofs[j] = t;
    end
    for (int k = 0; k < 8; k++) begin
      phase = ofs[k];
      for (int m = 0; m < 3; m++) step();
      pulse_start();
      wait_lock((ofs[k] + 1) * (SETTLE + 1) + MATCH_CNT + 2, n);
      chk($sformatf("t2_locked_%0d", ofs[k]), {15'h0, locked}, 16'h1);
      chk($sformatf("t2_slip_%0d", ofs[k]), {13'h0, slip_pos}, 16'(ofs[k]));
      step();
      chk($sformatf("t2_dout_%0d", ofs[k]), {8'h0, dout}, {8'h0, exp_dout(ofs[k])});
    end

    // Test 3: no pattern -> fail after MAX_SWEEPS sweeps
    mode = M_ZERO;
    for (int k = 0; k < 3; k++) step();
    pulse_start();
    n = 0; early = 0;
    while (align_fail !== 1'b1 && n < 40 * (SETTLE + 1)) begin
      step();
      n++;
      if (locked !== 1'b0) early++;
    end
    chk("t3_fail", {15'h0, align_fail}, 16'h1);
    chk("t3_fail_time", 16'(n >= (8 * MAX_SWEEPS - 1) * (SETTLE + 1) &&
                            n <= 8 * MAX_SWEEPS * (SETTLE + 1) + 4), 16'h1);
    chk("t3_no_lock", 16'(early), 16'h0);
    for (int k = 0; k < 5; k++) step();
    chk("t3_sticky", {15'h0, align_fail}, 16'h1);
    pulse_start();
    chk("t3_cleared", {15'h0, align_fail}, 16'h0);

    // Test 4: lock at 5, 3 bad frames tolerated, 4 force relock
    mode = M_TRAIN; phase = 5; train_active = 1'b1;
    for (int k = 0; k < 3; k++) step();
    pulse_start();
    wait_lock(6 * (SETTLE + 1) + MATCH_CNT + 2, n);
    chk("t4_locked", {15'h0, locked}, 16'h1);
    f0 = next_frame() + 3;
    for (int k = 0; k < 3; k++) flip_frame[f0 + k] = 1'b1;
    drops = 0; vbad = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (locked !== 1'b1) drops++;
      if (dout_valid !== locked) vbad++;
      if (dout !== exp_dout(5)) bad++;
    end
    chk("t4_3bad_drops", 16'(drops), 16'h0);
    chk("t4_valid_eq", 16'(vbad), 16'h0);
    chk("t4_3bad_dout", 16'(bad), 16'h0);
    f0 = next_frame() + 3;
    for (int k = 0; k < 4; k++) flip_frame[f0 + k] = 1'b1;
    run = 0; reached = 0; early = 0;
    for (int k = 0; k < 30 && reached == 0; k++) begin
      step();
      if (run >= ERR_LIMIT) begin
        chk("t4_drop", {15'h0, locked}, 16'h0);
        chk("t4_drop_valid", {15'h0, dout_valid}, 16'h0);
        reached = 1;
      end else begin
        if (locked !== 1'b1) early++;
        run = (exp_dout(5) !== PAT) ? run + 1 : 0;
      end
    end
    chk("t4_reached", 16'(reached), 16'h1);
    chk("t4_early_drop", 16'(early), 16'h0);
    wait_lock(9 * (SETTLE + 1) + MATCH_CNT + 4, n);
    chk("t4_relocked", {15'h0, locked}, 16'h1);
    chk("t4_relock_slip", {13'h0, slip_pos}, 16'd5);

    // Test 5: payload with train_active=0 passes through, lock held
    train_active = 1'b0;
    mode = M_PAY;
    c3_frame = next_frame();
    bad = 0; drops = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (locked !== 1'b1) drops++;
      if (dout !== exp_dout(5)) bad++;
      if (bits_q.size() / 8 - 3 == c3_frame) chk("t5_first_c3", {8'h0, dout}, 16'h00C3);
    end
    chk("t5_dout", 16'(bad), 16'h0);
    chk("t5_no_relock", 16'(drops), 16'h0);
    chk("t5_slip", {13'h0, slip_pos}, 16'd5);

`ifdef RX_ALIGN_ERR_CNT_EN
    // err_cnt: 10 bad frames in runs shorter than ERR_LIMIT
    mode = M_TRAIN;
    for (int k = 0; k < 4; k++) step();
    pulse_start();
    chk("ec_cleared", err_cnt, 16'h0);
    wait_lock(6 * (SETTLE + 1) + MATCH_CNT + 2, n);
    train_active = 1'b1;
    f0 = next_frame() + 3;
    for (int k = 0; k < 13; k++) if (k % 4 != 3) flip_frame[f0 + k] = 1'b1;
    for (int k = 0; k < 24; k++) step();
    chk("ec_locked", {15'h0, locked}, 16'h1);
    chk("ec_count", err_cnt, 16'd10);
`endif

    // Test 6: reset mid-CHECK
    mode = M_TRAIN; phase = 0; train_active = 1'b1;
    for (int k = 0; k < 3; k++) step();
    pulse_start();
    for (int k = 0; k < SETTLE + 3; k++) step();
    rst_n = 1'b0;
    step();
    chk("t6_dout", {8'h0, dout}, 16'h0);
    chk("t6_valid", {15'h0, dout_valid}, 16'h0);
    chk("t6_locked", {15'h0, locked}, 16'h0);
    chk("t6_fail", {15'h0, align_fail}, 16'h0);
    chk("t6_slip", {13'h0, slip_pos}, 16'h0);
`ifdef RX_ALIGN_ERR_CNT_EN
    chk("t6_err_cnt", err_cnt, 16'h0);
`endif
    rst_n = 1'b1;
    early = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (locked !== 1'b0) early++;
    end
    chk("t6_stays_idle", 16'(early), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
